// File: rtl/edge_pkg.sv
// Shared edge-selection encodings for the edge detector and the UART RX block.
// The mode field is 2 bits per channel: 00 off, 01 rise, 10 fall, 11 both.
package edge_pkg;

   localparam logic [1:0] EDGE_OFF  = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;
   localparam logic [1:0] EDGE_BOTH = 2'b11;

   // True when a transition to new_level is one the selected mode reports.
   function automatic logic edge_match(input logic [1:0] mode, input logic new_level);
      logic hit;
      hit = 1'b0;
      case (mode)
         EDGE_OFF:  hit = 1'b0;
         EDGE_RISE: hit = new_level;
         EDGE_FALL: hit = ~new_level;
         EDGE_BOTH: hit = 1'b1;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/edge_chan.sv
// Single edge-detector channel: synchroniser chain, optional glitch filter,
// edge-type qualification, one-cycle pulse and sticky flag.
// Optional glitch filter is built only when MULTI_EDGE_FILTER_EN is defined;
// otherwise the filtered level simply follows the synchroniser output.
module edge_chan
   import edge_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4,
   parameter logic        RST_LEVEL   = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       pin_i,
   input  logic [1:0] mode_i,
   input  logic       flag_clr_i,
   output logic       level_o,
   output logic       pulse_o,
   output logic       rise_o,
   output logic       flag_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_lvl;
   logic                   level_q, level_d;
   logic                   upd;
   logic                   pulse_q, pulse_d;
   logic                   rise_q, rise_d;
   logic                   flag_q, flag_d;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   // Metastability chain: plain shift register, last stage feeds the filter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {SYNC_STAGES{RST_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      end
   end

`ifdef MULTI_EDGE_FILTER_EN
   localparam int unsigned    CNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Accept a new level only after it has been stable for FILT_LEN cycles;
   // any return to the current level discards the pending change.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      upd     = 1'b0;
      if (sync_lvl != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_lvl;
            upd     = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Stability counter state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic [31:0] unused_filt_len;
   assign unused_filt_len = FILT_LEN;

   // Without the filter the level tracks the synchroniser every cycle.
   always_comb begin
      level_d = sync_lvl;
      upd     = (sync_lvl != level_q);
   end
`endif

   // Pulse on accepted transitions the mode selects; sticky flag set wins over clear.
   always_comb begin
      pulse_d = upd & edge_match(mode_i, level_d);
      rise_d  = level_d;
      flag_d  = pulse_q | (flag_q & ~flag_clr_i);
   end

   // Output registers: level, pulse, edge direction and sticky flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q <= RST_LEVEL;
         pulse_q <= 1'b0;
         rise_q  <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         level_q <= level_d;
         pulse_q <= pulse_d;
         rise_q  <= rise_d;
         flag_q  <= flag_d;
      end
   end

   assign level_o = level_q;
   assign pulse_o = pulse_q;
   assign rise_o  = rise_q;
   assign flag_o  = flag_q;

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector between raw pins and the UART RX / control logic.
// A falling-edge pulse on an RX line serves as the start-bit trigger.
// Build option: define MULTI_EDGE_FILTER_EN to include the per-channel glitch filter.
module multi_edge_detect
   import edge_pkg::*;
#(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4,
   parameter logic        RST_LEVEL   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   pin_in,
   input  logic [2*N_CH-1:0] mode,
   input  logic [N_CH-1:0]   flag_clr,
   output logic [N_CH-1:0]   level_out,
   output logic [N_CH-1:0]   edge_pulse,
   output logic [N_CH-1:0]   edge_rise,
   output logic [N_CH-1:0]   edge_flag,
   output logic              irq
);

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      edge_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_LEN    (FILT_LEN),
         .RST_LEVEL   (RST_LEVEL)
      ) u_chan (
         .clk_i      (clk),
         .rst_ni     (rst_n),
         .pin_i      (pin_in[i]),
         .mode_i     (mode[2*i +: 2]),
         .flag_clr_i (flag_clr[i]),
         .level_o    (level_out[i]),
         .pulse_o    (edge_pulse[i]),
         .rise_o     (edge_rise[i]),
         .flag_o     (edge_flag[i])
      );
   end

   assign irq = |edge_flag;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect at default parameters.
module tb_multi_edge_detect;

   localparam int N_CH        = 4;
   localparam int SYNC_STAGES = 2;
   localparam int FILT_LEN    = 4;
`ifdef MULTI_EDGE_FILTER_EN
   localparam int EFF = FILT_LEN;
`else
   localparam int EFF = 1;
`endif
   // Edges after e0 until level_out / edge_pulse update.
   localparam int LAT = SYNC_STAGES + EFF - 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] pin_in;
   logic [7:0] mode;
   logic [3:0] flag_clr;
   logic [3:0] level_out, edge_pulse, edge_rise, edge_flag;
   logic       irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_edge_detect #(
      .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .RST_LEVEL(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .mode(mode), .flag_clr(flag_clr),
      .level_out(level_out), .edge_pulse(edge_pulse), .edge_rise(edge_rise),
      .edge_flag(edge_flag), .irq(irq)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pin_in = 4'h0; mode = 8'hAA; flag_clr = 4'h0;
      repeat (3) step();
      checks++; if (level_out !== 4'hF) begin errors++; $display("FAIL reset_level got=%b exp=%b", level_out, 4'hF); end
      checks++; if (edge_pulse !== 4'h0) begin errors++; $display("FAIL reset_pulse got=%b exp=%b", edge_pulse, 4'h0); end
      checks++; if (edge_flag !== 4'h0) begin errors++; $display("FAIL reset_flag got=%b exp=%b", edge_flag, 4'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
      rst_n = 1'b1;
      #1;
      checks++; if (level_out !== 4'hF) begin errors++; $display("FAIL release_level got=%b exp=%b", level_out, 4'hF); end
      for (int k = 1; k <= LAT + 4; k++) begin
         logic [3:0] ep;
         step();
         ep = (k == LAT + 1) ? 4'hF : 4'h0;
         checks++; if (edge_pulse !== ep) begin errors++; $display("FAIL release_pulse k=%0d got=%b exp=%b", k, edge_pulse, ep); end
         if (k == LAT + 1) begin
            checks++; if (edge_rise !== 4'h0) begin errors++; $display("FAIL release_rise got=%b exp=%b", edge_rise, 4'h0); end
         end
      end
      checks++; if (level_out !== 4'h0) begin errors++; $display("FAIL release_level_after got=%b exp=%b", level_out, 4'h0); end
      checks++; if (edge_flag !== 4'hF) begin errors++; $display("FAIL release_flag got=%b exp=%b", edge_flag, 4'hF); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL release_irq got=%b exp=1", irq); end
      flag_clr = 4'hF; step(); flag_clr = 4'h0;
      checks++; if (edge_flag !== 4'h0) begin errors++; $display("FAIL clear_all_flag got=%b exp=%b", edge_flag, 4'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clear_all_irq got=%b exp=0", irq); end
   endtask

   task automatic test_rise_mode();
      mode = 8'h01;
      pin_in[0] = 1'b1;
      for (int k = 1; k <= LAT + 4; k++) begin
         logic [3:0] ep;
         step();
         ep = (k == LAT + 1) ? 4'b0001 : 4'b0000;
         checks++; if (edge_pulse !== ep) begin errors++; $display("FAIL rise_pulse k=%0d got=%b exp=%b", k, edge_pulse, ep); end
         checks++; if (level_out[0] !== (k >= LAT + 1)) begin errors++; $display("FAIL rise_level k=%0d got=%b exp=%b", k, level_out[0], (k >= LAT + 1)); end
         if (k == LAT + 1) begin
            checks++; if (edge_rise[0] !== 1'b1) begin errors++; $display("FAIL rise_dir got=%b exp=1", edge_rise[0]); end
         end
      end
      // falling edge in rise mode: ignored
      pin_in[0] = 1'b0;
      for (int k = 1; k <= LAT + 4; k++) begin
         step();
         checks++; if (edge_pulse !== 4'h0) begin errors++; $display("FAIL rise_mode_fall k=%0d got=%b exp=%b", k, edge_pulse, 4'h0); end
      end
      // rising edge in fall mode: no pulse, level still follows
      mode = 8'h02;
      pin_in[0] = 1'b1;
      for (int k = 1; k <= LAT + 4; k++) begin
         step();
         checks++; if (edge_pulse !== 4'h0) begin errors++; $display("FAIL fall_mode_rise k=%0d got=%b exp=%b", k, edge_pulse, 4'h0); end
      end
      checks++; if (level_out[0] !== 1'b1) begin errors++; $display("FAIL fall_mode_level got=%b exp=1", level_out[0]); end
      // transition while off is lost and not replayed when re-enabled
      mode = 8'h00;
      pin_in[0] = 1'b0;
      for (int k = 1; k <= LAT + 4; k++) begin
         step();
         checks++; if (edge_pulse !== 4'h0) begin errors++; $display("FAIL off_mode k=%0d got=%b exp=%b", k, edge_pulse, 4'h0); end
      end
      checks++; if (level_out[0] !== 1'b0) begin errors++; $display("FAIL off_mode_level got=%b exp=0", level_out[0]); end
      mode = 8'h03;
      for (int k = 1; k <= LAT + 4; k++) begin
         step();
         checks++; if (edge_pulse !== 4'h0) begin errors++; $display("FAIL no_replay k=%0d got=%b exp=%b", k, edge_pulse, 4'h0); end
      end
   endtask

   task automatic test_glitch(input int g);
      mode = 8'h0C;
      pin_in[1] = 1'b1;
      repeat (LAT + 4) step();
      pin_in[1] = 1'b0;
      for (int k = 1; k <= g + LAT + 4; k++) begin
         logic [3:0] ep;
         logic       er, el;
         if (k == g + 1) pin_in[1] = 1'b1;
         step();
         ep = 4'b0000; er = 1'b0;
         if (g >= EFF && k == LAT + 1) begin ep = 4'b0010; er = 1'b0; end
         if (g >= EFF && k == LAT + 1 + g) begin ep = 4'b0010; er = 1'b1; end
         el = (g >= EFF && k >= LAT + 1 && k <= LAT + g) ? 1'b0 : 1'b1;
         checks++; if (edge_pulse !== ep) begin errors++; $display("FAIL glitch%0d_pulse k=%0d got=%b exp=%b", g, k, edge_pulse, ep); end
         checks++; if (level_out[1] !== el) begin errors++; $display("FAIL glitch%0d_level k=%0d got=%b exp=%b", g, k, level_out[1], el); end
         if (ep[1]) begin
            checks++; if (edge_rise[1] !== er) begin errors++; $display("FAIL glitch%0d_dir k=%0d got=%b exp=%b", g, k, edge_rise[1], er); end
         end
      end
   endtask

   task automatic test_flag_race();
      mode = 8'h30;
      flag_clr = 4'hF; step(); flag_clr = 4'h0;
      checks++; if (edge_flag !== 4'h0) begin errors++; $display("FAIL race_pre_flag got=%b exp=%b", edge_flag, 4'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL race_pre_irq got=%b exp=0", irq); end
      pin_in[2] = 1'b1;
      repeat (LAT + 1) step();
      checks++; if (edge_pulse !== 4'b0100) begin errors++; $display("FAIL race_pulse got=%b exp=%b", edge_pulse, 4'b0100); end
      flag_clr = 4'b0100;
      step();
      checks++; if (edge_flag[2] !== 1'b1) begin errors++; $display("FAIL race_set_wins got=%b exp=1", edge_flag[2]); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_irq_set got=%b exp=1", irq); end
      checks++; if (edge_pulse !== 4'h0) begin errors++; $display("FAIL race_one_cycle got=%b exp=%b", edge_pulse, 4'h0); end
      step();
      checks++; if (edge_flag !== 4'h0) begin errors++; $display("FAIL race_clear got=%b exp=%b", edge_flag, 4'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL race_irq_clear got=%b exp=0", irq); end
      flag_clr = 4'h0;
      step();
      checks++; if (edge_flag !== 4'h0) begin errors++; $display("FAIL race_stay_clear got=%b exp=%b", edge_flag, 4'h0); end
   endtask

   task automatic test_reset_mid();
      mode = 8'hC0;
      pin_in = 4'hF;
      repeat (LAT - 1) step();
      checks++; if (edge_pulse !== 4'h0) begin errors++; $display("FAIL mid_pre_pulse got=%b exp=%b", edge_pulse, 4'h0); end
      checks++; if (level_out[3] !== 1'b0) begin errors++; $display("FAIL mid_pre_level got=%b exp=0", level_out[3]); end
      rst_n = 1'b0;
      #1;
      checks++; if (level_out !== 4'hF) begin errors++; $display("FAIL mid_rst_level got=%b exp=%b", level_out, 4'hF); end
      checks++; if (edge_pulse !== 4'h0) begin errors++; $display("FAIL mid_rst_pulse got=%b exp=%b", edge_pulse, 4'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got=%b exp=0", irq); end
      repeat (2) step();
      rst_n = 1'b1;
      for (int k = 1; k <= LAT + 4; k++) begin
         step();
         checks++; if (edge_pulse !== 4'h0) begin errors++; $display("FAIL mid_quiet k=%0d got=%b exp=%b", k, edge_pulse, 4'h0); end
         checks++; if (level_out[3] !== 1'b1) begin errors++; $display("FAIL mid_quiet_level k=%0d got=%b exp=1", k, level_out[3]); end
      end
      pin_in[3] = 1'b0;
      for (int k = 1; k <= LAT + 4; k++) begin
         logic [3:0] ep;
         step();
         ep = (k == LAT + 1) ? 4'b1000 : 4'b0000;
         checks++; if (edge_pulse !== ep) begin errors++; $display("FAIL mid_restart k=%0d got=%b exp=%b", k, edge_pulse, ep); end
         checks++; if (level_out[3] !== (k < LAT + 1)) begin errors++; $display("FAIL mid_restart_level k=%0d got=%b exp=%b", k, level_out[3], (k < LAT + 1)); end
      end
   endtask

   task automatic test_simultaneous();
      mode = 8'hFF;
      pin_in = 4'b1000;
      for (int k = 1; k <= LAT + 3; k++) begin
         logic [3:0] ep;
         step();
         ep = (k == LAT + 1) ? 4'hF : 4'h0;
         checks++; if (edge_pulse !== ep) begin errors++; $display("FAIL simul_pulse k=%0d got=%b exp=%b", k, edge_pulse, ep); end
         if (k == LAT + 1) begin
            checks++; if (edge_rise !== 4'b1000) begin errors++; $display("FAIL simul_dir got=%b exp=%b", edge_rise, 4'b1000); end
         end
      end
      checks++; if (level_out !== 4'b1000) begin errors++; $display("FAIL simul_level got=%b exp=%b", level_out, 4'b1000); end
   endtask

   initial begin
      test_reset();
      test_rise_mode();
      test_glitch(1);
      test_glitch(3);
      test_glitch(4);
      test_flag_race();
      test_reset_mid();
      test_simultaneous();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
